// File: rtl/stack_queue_if.sv
// Bundles the request and status signals of the combined stack/queue block.
interface stack_queue_if #(
   parameter int unsigned STACK_DEPTH = 8,
   parameter int unsigned WORD_LEN    = 8
);
   localparam int unsigned CNT_W = $clog2(STACK_DEPTH) + 1;

   logic                mode;
   logic                push;
   logic                pop;
   logic                clear;
   logic [WORD_LEN-1:0] data_in;
   logic [WORD_LEN-1:0] data_out;
   logic                out_valid;
   logic [WORD_LEN-1:0] top;
   logic [CNT_W-1:0]    count;
   logic                full;
   logic                empty;
   logic                overflow;
   logic                underflow;

   // Requester side: drives operations, observes data and status.
   modport master (
      output mode, push, pop, clear, data_in,
      input  data_out, out_valid, top, count, full, empty, overflow, underflow
   );

   // Storage side: accepts operations, reports data and status.
   modport slave (
      input  mode, push, pop, clear, data_in,
      output data_out, out_valid, top, count, full, empty, overflow, underflow
   );
endinterface

// File: rtl/stack_queue.sv
// Circular-buffer store that behaves as a LIFO or FIFO; the mode is frozen while occupied.
module stack_queue #(
   parameter int unsigned STACK_DEPTH = 8,
   parameter int unsigned WORD_LEN    = 8
) (
   input  logic         clk,
   input  logic         rstn,
   stack_queue_if.slave bus
);
   localparam int unsigned PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(STACK_DEPTH) + 1;

   localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(STACK_DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(STACK_DEPTH);
   localparam logic             MODE_LIFO = 1'b0;
   localparam logic             MODE_FIFO = 1'b1;

   logic [WORD_LEN-1:0] mem [STACK_DEPTH];

   logic [PTR_W-1:0]    rd_ptr;
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr_nxt;
   logic [PTR_W-1:0]    wr_ptr_nxt;
   logic [PTR_W-1:0]    rd_ptr_inc;
   logic [PTR_W-1:0]    wr_ptr_inc;
   logic [PTR_W-1:0]    wr_ptr_dec;
   logic [CNT_W-1:0]    count_q;
   logic [CNT_W-1:0]    count_nxt;
   logic                mode_q;
   logic                eff_mode;
   logic [WORD_LEN-1:0] data_out_q;
   logic [WORD_LEN-1:0] data_out_nxt;
   logic                out_valid_q;
   logic                out_valid_nxt;
   logic                overflow_q;
   logic                overflow_nxt;
   logic                underflow_q;
   logic                underflow_nxt;
   logic                empty_c;
   logic                full_c;
   logic [PTR_W-1:0]    rd_addr;
   logic [WORD_LEN-1:0] rd_word;
   logic                mem_we;
   logic [PTR_W-1:0]    mem_waddr;

   // Occupancy flags, effective mode and the word the next pop would return.
   always_comb begin
      empty_c    = (count_q == '0);
      full_c     = (count_q == CNT_FULL);
      eff_mode   = empty_c ? bus.mode : mode_q;
      rd_ptr_inc = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      wr_ptr_inc = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      wr_ptr_dec = (wr_ptr == '0) ? PTR_LAST : wr_ptr - PTR_W'(1);
      rd_addr    = (eff_mode == MODE_FIFO) ? rd_ptr : wr_ptr_dec;
      rd_word    = mem[rd_addr];
   end

   // Next-state decode of clear / push / pop; clear wins, flags are single-cycle pulses.
   always_comb begin
      rd_ptr_nxt    = rd_ptr;
      wr_ptr_nxt    = wr_ptr;
      count_nxt     = count_q;
      data_out_nxt  = data_out_q;
      out_valid_nxt = 1'b0;
      overflow_nxt  = 1'b0;
      underflow_nxt = 1'b0;
      mem_we        = 1'b0;
      mem_waddr     = wr_ptr;

      if (bus.clear) begin
         rd_ptr_nxt = '0;
         wr_ptr_nxt = '0;
         count_nxt  = '0;
      end else if (bus.push && bus.pop) begin
         out_valid_nxt = 1'b1;
         if (empty_c) begin
            // Nothing stored: the incoming word passes straight through.
            data_out_nxt = bus.data_in;
         end else begin
            data_out_nxt = rd_word;
            mem_we       = 1'b1;
            if (eff_mode == MODE_FIFO) begin
               rd_ptr_nxt = rd_ptr_inc;
               wr_ptr_nxt = wr_ptr_inc;
            end else begin
               // Stack: replace the top entry in place.
               mem_waddr = wr_ptr_dec;
            end
         end
      end else if (bus.push) begin
         if (full_c) begin
            overflow_nxt = 1'b1;
         end else begin
            mem_we     = 1'b1;
            wr_ptr_nxt = wr_ptr_inc;
            count_nxt  = count_q + CNT_W'(1);
         end
      end else if (bus.pop) begin
         if (empty_c) begin
            underflow_nxt = 1'b1;
         end else begin
            data_out_nxt  = rd_word;
            out_valid_nxt = 1'b1;
            count_nxt     = count_q - CNT_W'(1);
            if (eff_mode == MODE_FIFO) begin
               rd_ptr_nxt = rd_ptr_inc;
            end else begin
               wr_ptr_nxt = wr_ptr_dec;
            end
         end
      end
   end

   // Control and output registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count_q     <= '0;
         mode_q      <= MODE_LIFO;
         data_out_q  <= '0;
         out_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         rd_ptr      <= rd_ptr_nxt;
         wr_ptr      <= wr_ptr_nxt;
         count_q     <= count_nxt;
         mode_q      <= eff_mode;
         data_out_q  <= data_out_nxt;
         out_valid_q <= out_valid_nxt;
         overflow_q  <= overflow_nxt;
         underflow_q <= underflow_nxt;
      end
   end

   // Storage array; reset clears every word so stale data never reaches top.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mem <= '{default: '0};
      end else if (mem_we) begin
         mem[mem_waddr] <= bus.data_in;
      end
   end

   // Status and data outputs.
   always_comb begin
      bus.data_out  = data_out_q;
      bus.out_valid = out_valid_q;
      bus.overflow  = overflow_q;
      bus.underflow = underflow_q;
      bus.count     = count_q;
      bus.full      = full_c;
      bus.empty     = empty_c;
      bus.top       = empty_c ? '0 : rd_word;
   end
endmodule

// File: tb/tb_stack_queue.sv
// Directed bench for stack_queue: a depth-8 and a depth-5 instance share clock and reset.
module tb_stack_queue;
   logic clk;
   logic rstn;
   int   total;
   int   passed;

   stack_queue_if #(.STACK_DEPTH(8), .WORD_LEN(8)) bus8 ();
   stack_queue_if #(.STACK_DEPTH(5), .WORD_LEN(8)) bus5 ();

   stack_queue #(.STACK_DEPTH(8), .WORD_LEN(8)) dut8 (.clk(clk), .rstn(rstn), .bus(bus8));
   stack_queue #(.STACK_DEPTH(5), .WORD_LEN(8)) dut5 (.clk(clk), .rstn(rstn), .bus(bus5));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One cycle of traffic on the depth-8 instance; returns 1 time unit after the edge, idle.
   task automatic op8(input logic m, input logic pu, input logic po, input logic cl, input logic [7:0] d);
      bus8.mode = m; bus8.push = pu; bus8.pop = po; bus8.clear = cl; bus8.data_in = d;
      @(posedge clk);
      #1;
      bus8.push = 1'b0; bus8.pop = 1'b0; bus8.clear = 1'b0;
   endtask

   task automatic op5(input logic m, input logic pu, input logic po, input logic [7:0] d);
      bus5.mode = m; bus5.push = pu; bus5.pop = po; bus5.clear = 1'b0; bus5.data_in = d;
      @(posedge clk);
      #1;
      bus5.push = 1'b0; bus5.pop = 1'b0;
   endtask

   initial begin
      total  = 0;
      passed = 0;
      rstn   = 1'b0;
      bus8.mode = 1'b0; bus8.push = 1'b0; bus8.pop = 1'b0; bus8.clear = 1'b0; bus8.data_in = '0;
      bus5.mode = 1'b0; bus5.push = 1'b0; bus5.pop = 1'b0; bus5.clear = 1'b0; bus5.data_in = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;

      // Reset state
      chk("rst_count", 32'(bus8.count), 32'd0);
      chk("rst_empty", 32'(bus8.empty), 32'd1);
      chk("rst_full", 32'(bus8.full), 32'd0);
      chk("rst_dout", 32'(bus8.data_out), 32'd0);
      chk("rst_top", 32'(bus8.top), 32'd0);
      chk("rst_valid", 32'(bus8.out_valid), 32'd0);

      // LIFO fill, overflow, drain in reverse order
      for (int i = 1; i <= 8; i++) op8(1'b0, 1'b1, 1'b0, 1'b0, 8'(i));
      chk("lifo_full", 32'(bus8.full), 32'd1);
      chk("lifo_count8", 32'(bus8.count), 32'd8);
      chk("lifo_top8", 32'(bus8.top), 32'd8);
      op8(1'b0, 1'b1, 1'b0, 1'b0, 8'd9);
      chk("lifo_ovf_pulse", 32'(bus8.overflow), 32'd1);
      chk("lifo_ovf_count", 32'(bus8.count), 32'd8);
      op8(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      chk("lifo_ovf_drop", 32'(bus8.overflow), 32'd0);
      for (int k = 8; k >= 1; k--) begin
         op8(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
         chk("lifo_pop_data", 32'(bus8.data_out), 32'(k));
         chk("lifo_pop_valid", 32'(bus8.out_valid), 32'd1);
      end
      chk("lifo_drained", 32'(bus8.empty), 32'd1);
      chk("lifo_drained_top", 32'(bus8.top), 32'd0);
      op8(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      chk("valid_one_cycle", 32'(bus8.out_valid), 32'd0);

      // LIFO simultaneous push/pop replaces the top
      op8(1'b0, 1'b1, 1'b0, 1'b0, 8'd3);
      op8(1'b0, 1'b1, 1'b0, 1'b0, 8'd7);
      op8(1'b0, 1'b1, 1'b1, 1'b0, 8'd9);
      chk("lifo_pp_data", 32'(bus8.data_out), 32'd7);
      chk("lifo_pp_top", 32'(bus8.top), 32'd9);
      chk("lifo_pp_count", 32'(bus8.count), 32'd2);
      chk("lifo_pp_valid", 32'(bus8.out_valid), 32'd1);
      op8(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
      chk("lifo_pp_pop9", 32'(bus8.data_out), 32'd9);
      op8(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
      chk("lifo_pp_pop3", 32'(bus8.data_out), 32'd3);

      // Empty bypass
      op8(1'b0, 1'b1, 1'b1, 1'b0, 8'h55);
      chk("byp_data", 32'(bus8.data_out), 32'h55);
      chk("byp_valid", 32'(bus8.out_valid), 32'd1);
      chk("byp_count", 32'(bus8.count), 32'd0);
      chk("byp_ovf", 32'(bus8.overflow), 32'd0);
      chk("byp_unf", 32'(bus8.underflow), 32'd0);

      // FIFO full with simultaneous push/pop
      for (int i = 1; i <= 8; i++) op8(1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h10 + i));
      chk("fifo_full", 32'(bus8.full), 32'd1);
      chk("fifo_top", 32'(bus8.top), 32'h11);
      op8(1'b1, 1'b1, 1'b1, 1'b0, 8'h99);
      chk("fifo_pp_data", 32'(bus8.data_out), 32'h11);
      chk("fifo_pp_count", 32'(bus8.count), 32'd8);
      chk("fifo_pp_full", 32'(bus8.full), 32'd1);
      for (int i = 2; i <= 8; i++) begin
         op8(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
         chk("fifo_drain", 32'(bus8.data_out), 32'(8'h10 + i));
      end
      op8(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
      chk("fifo_drain_last", 32'(bus8.data_out), 32'h99);
      chk("fifo_drain_empty", 32'(bus8.empty), 32'd1);

      // Mode latch: a mode change while occupied is ignored
      op8(1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
      op8(1'b1, 1'b1, 1'b0, 1'b0, 8'd2);
      op8(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
      chk("latch_fifo_pop", 32'(bus8.data_out), 32'd1);
      op8(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
      chk("latch_fifo_pop2", 32'(bus8.data_out), 32'd2);
      chk("latch_empty", 32'(bus8.empty), 32'd1);
      op8(1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
      op8(1'b0, 1'b1, 1'b0, 1'b0, 8'd2);
      op8(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
      chk("latch_lifo_pop", 32'(bus8.data_out), 32'd2);
      op8(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
      chk("latch_lifo_pop2", 32'(bus8.data_out), 32'd1);

      // Underflow keeps data_out and out_valid low
      op8(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
      chk("unf_pulse", 32'(bus8.underflow), 32'd1);
      chk("unf_valid", 32'(bus8.out_valid), 32'd0);
      chk("unf_dout_hold", 32'(bus8.data_out), 32'd1);
      op8(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      chk("unf_drop", 32'(bus8.underflow), 32'd0);

      // Clear beats a concurrent push
      op8(1'b0, 1'b1, 1'b0, 1'b0, 8'hA1);
      op8(1'b0, 1'b1, 1'b0, 1'b0, 8'hA2);
      op8(1'b0, 1'b1, 1'b0, 1'b0, 8'hA3);
      chk("clr_pre_count", 32'(bus8.count), 32'd3);
      op8(1'b0, 1'b1, 1'b0, 1'b1, 8'hEE);
      chk("clr_count", 32'(bus8.count), 32'd0);
      chk("clr_empty", 32'(bus8.empty), 32'd1);
      chk("clr_top", 32'(bus8.top), 32'd0);
      chk("clr_dout_hold", 32'(bus8.data_out), 32'd1);
      chk("clr_ovf", 32'(bus8.overflow), 32'd0);

      // FIFO wrap on the depth-5 instance
      op5(1'b1, 1'b1, 1'b0, 8'd10);
      op5(1'b1, 1'b1, 1'b0, 8'd20);
      op5(1'b1, 1'b1, 1'b0, 8'd30);
      op5(1'b1, 1'b0, 1'b1, 8'd0);
      chk("d5_pop10", 32'(bus5.data_out), 32'd10);
      op5(1'b1, 1'b0, 1'b1, 8'd0);
      chk("d5_pop20", 32'(bus5.data_out), 32'd20);
      op5(1'b1, 1'b1, 1'b0, 8'd40);
      op5(1'b1, 1'b1, 1'b0, 8'd50);
      op5(1'b1, 1'b1, 1'b0, 8'd60);
      op5(1'b1, 1'b1, 1'b0, 8'd70);
      chk("d5_full", 32'(bus5.full), 32'd1);
      chk("d5_count", 32'(bus5.count), 32'd5);
      chk("d5_top", 32'(bus5.top), 32'd30);
      for (int i = 3; i <= 7; i++) begin
         op5(1'b1, 1'b0, 1'b1, 8'd0);
         chk("d5_drain", 32'(bus5.data_out), 32'(i * 10));
      end
      chk("d5_empty", 32'(bus5.empty), 32'd1);

      // Asynchronous reset between edges
      for (int i = 1; i <= 4; i++) op8(1'b0, 1'b1, 1'b0, 1'b0, 8'(8'hC0 + i));
      op8(1'b0, 1'b1, 1'b1, 1'b0, 8'hC9);
      chk("ar_pre_count", 32'(bus8.count), 32'd4);
      chk("ar_pre_dout", 32'(bus8.data_out), 32'hC4);
      #2;
      rstn = 1'b0;
      #1;
      chk("ar_count", 32'(bus8.count), 32'd0);
      chk("ar_dout", 32'(bus8.data_out), 32'd0);
      chk("ar_top", 32'(bus8.top), 32'd0);
      chk("ar_empty", 32'(bus8.empty), 32'd1);
      chk("ar_full", 32'(bus8.full), 32'd0);
      chk("ar_valid", 32'(bus8.out_valid), 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      #1;
      chk("ar_rel_empty", 32'(bus8.empty), 32'd1);
      chk("ar_rel_top", 32'(bus8.top), 32'd0);
      op8(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      chk("ar_rel_count", 32'(bus8.count), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/stack_queue.md
STACK_QUEUE -- requirements
Module: stack_queue

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 8; entry count, any integer >= 2, not limited to powers of two.
REQ-002 SHALL have parameter WORD_LEN, default 8; data width in bits.
REQ-003 SHALL have port clk, input, 1 bit; the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn, input, 1 bit; reset, asynchronous and active-low.
REQ-005 SHALL have port mode, input, 1 bit; 0 = LIFO, 1 = FIFO.
REQ-006 SHALL have port push, input, 1 bit; write request.
REQ-007 SHALL have port pop, input, 1 bit; read request.
REQ-008 SHALL have port clear, input, 1 bit; synchronous flush.
REQ-009 SHALL have port data_in, input, WORD_LEN bits; write data.
REQ-010 SHALL have port data_out, output, WORD_LEN bits; registered read data.
REQ-011 SHALL have port out_valid, output, 1 bit; data_out updated this cycle.
REQ-012 SHALL have port top, output, WORD_LEN bits; combinational peek of the entry the next pop returns.
REQ-013 SHALL have port count, output, $clog2(STACK_DEPTH)+1 bits; occupancy.
REQ-014 SHALL have port full, output, 1 bit; count == STACK_DEPTH.
REQ-015 SHALL have port empty, output, 1 bit; count == 0.
REQ-016 SHALL have port overflow, output, 1 bit; one-cycle pulse on a rejected push.
REQ-017 SHALL have port underflow, output, 1 bit; one-cycle pulse on a rejected pop.

Function
REQ-018 SHALL hold storage as a circular array with rd_ptr and wr_ptr, both wrapping modulo STACK_DEPTH; valid entries lie from rd_ptr up to wr_ptr-1.
REQ-019 SHALL use eff_mode = mode while empty, otherwise the latched mode; the latch loads eff_mode every cycle, so mode changes while non-empty are ignored.
REQ-020 SHALL, in FIFO mode: push writes at wr_ptr then wr_ptr+1; pop reads at rd_ptr then rd_ptr+1.
REQ-021 SHALL, in LIFO mode: push writes at wr_ptr then wr_ptr+1; pop reads at wr_ptr-1 then wr_ptr-1; rd_ptr is unchanged.
REQ-022 SHALL drive top from memory[rd_ptr] in FIFO mode and memory[wr_ptr-1] in LIFO mode, with eff_mode selecting; top SHALL be 0 when empty.
REQ-023 SHALL, on a successful pop: register the read word into data_out at the edge, assert out_valid for exactly the following cycle, and decrement count; latency is 1 cycle.
REQ-024 SHALL, on push only with full=0: store data_in and increment count.
REQ-025 SHALL, on push only with full=1: leave memory, pointers and count unchanged and pulse overflow.
REQ-026 SHALL, on pop only with empty=1: leave state unchanged, keep out_valid=0, hold data_out, and pulse underflow.
REQ-027 SHALL, on push and pop with count > 0 in FIFO mode: perform both (read rd_ptr, write wr_ptr, both advance) with count unchanged; this includes the full case.
REQ-028 SHALL, on push and pop with count > 0 in LIFO mode: set data_out to the old top, overwrite that slot with data_in, leave pointers and count unchanged, and assert out_valid.
REQ-029 SHALL, on push and pop with empty=1 in either mode: bypass, so data_out <= data_in, out_valid=1, count stays 0, and neither overflow nor underflow pulses.
REQ-030 SHALL give clear priority over push/pop: it zeroes rd_ptr, wr_ptr and count, sets out_valid, overflow and underflow to 0, holds data_out, and leaves memory contents as don't-care.
REQ-031 SHALL never wrap count past STACK_DEPTH or below 0.

Reset
REQ-032 SHALL, while rstn=0 and immediately on assertion: zero the pointers, count, latched mode (LIFO), data_out, out_valid, overflow, underflow and all memory words.
REQ-033 SHALL, after rstn deasserts mid-operation: discard all prior contents, so that empty=1, full=0 and top=0 before the next edge.

Verification
REQ-034 SHALL test LIFO, STACK_DEPTH=8: push 1..8 -> full=1, count=8; push 9 -> overflow pulse, count=8; eight pops -> data_out 8,7,...,1 each with out_valid; then empty=1.
REQ-035 SHALL test FIFO, STACK_DEPTH=5: push 10,20,30, pop 2, push 40,50,60,70 -> pointers wrap, full=1; five pops -> 30,40,50,60,70.
REQ-036 SHALL test simultaneous operations: LIFO holding 3,7 with push 9 and pop -> data_out=7, top=9, count=2; FIFO full with push and pop -> oldest out, count stays STACK_DEPTH; empty with push 0x55 and pop -> data_out=0x55, count=0, no flag pulses.
REQ-037 SHALL test mode latch: FIFO push 1,2, mode->0, pop -> data_out=1; drain to empty, mode=0, push 1,2, pop -> data_out=2.
REQ-038 SHALL test underflow and clear: pop on empty -> underflow pulse, data_out held; push 3 words, assert clear with push -> count=0, empty=1, no write.
REQ-039 SHALL test async reset: drop rstn between edges with count=4 -> count=0, data_out=0, top=0 immediately, without waiting for a clock edge.
